// File: rtl/axis_flit_deserializer.sv
// Packs narrow AXI-Stream flits into wide words with an assembly and an output register.
// Optional idle flush of partial words: define DESER_FLUSH_TIMEOUT_EN.
module axis_flit_deserializer #(
  parameter int IN_WIDTH       = 40,
  parameter int RATIO          = 4,
  parameter int CNT_WIDTH      = $clog2(RATIO + 1),
  parameter int TIMEOUT_CYCLES = 16,
  localparam int OUT_WIDTH     = IN_WIDTH * RATIO
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 s_TVALID,
  output logic                 s_TREADY,
  input  logic [IN_WIDTH-1:0]  s_TDATA,
  input  logic                 s_TLAST,
  output logic                 m_TVALID,
  input  logic                 m_TREADY,
  output logic [OUT_WIDTH-1:0] m_TDATA,
  output logic [CNT_WIDTH-1:0] m_TBEATS,
  output logic                 m_TLAST
);

  logic [CNT_WIDTH-1:0] r_cnt, r_hbeats, r_mbeats;
  logic [OUT_WIDTH-1:0] r_asm, r_mdata;
  logic                 r_done, r_hlast, r_mvalid, r_mlast;

  logic [CNT_WIDTH-1:0] w_cnt, w_hbeats, w_mbeats;
  logic [OUT_WIDTH-1:0] w_asm, w_mdata;
  logic                 w_done, w_hlast, w_mvalid, w_mlast;

  logic                 w_acc, w_out_free, w_xfer, w_fin, w_flush;
  logic [CNT_WIDTH-1:0] w_base_cnt, w_new_cnt;
  logic [OUT_WIDTH-1:0] w_new_data;

  assign s_TREADY   = !ARESET && !(r_done && r_mvalid && !m_TREADY);
  assign w_acc      = s_TVALID && s_TREADY;
  assign w_out_free = !r_mvalid || m_TREADY;
  assign w_xfer     = r_done && w_out_free;

  // A held word leaves this cycle, so an incoming beat starts a fresh word.
  assign w_base_cnt = r_done ? '0 : r_cnt;
  assign w_new_cnt  = w_base_cnt + CNT_WIDTH'(1);
  assign w_fin      = w_acc &&
                      (s_TLAST || w_base_cnt == CNT_WIDTH'(RATIO - 1));

  always_comb begin
    w_new_data = r_done ? '0 : r_asm;
    for (int k = 0; k < RATIO; k++) begin
      if (w_base_cnt == CNT_WIDTH'(k))
        w_new_data[k*IN_WIDTH +: IN_WIDTH] = s_TDATA;
    end
  end

`ifdef DESER_FLUSH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle;

  assign w_flush = !r_done && r_cnt != '0 && !w_acc &&
                   r_idle == IDLE_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge ACLK) begin
    if (ARESET || w_acc || w_flush || r_done || r_cnt == '0)
      r_idle <= '0;
    else
      r_idle <= r_idle + IDLE_W'(1);
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_flush = 1'b0;
`endif

  always_comb begin
    w_cnt    = r_cnt;
    w_asm    = r_asm;
    w_done   = r_done;
    w_hbeats = r_hbeats;
    w_hlast  = r_hlast;
    w_mvalid = r_mvalid;
    w_mdata  = r_mdata;
    w_mbeats = r_mbeats;
    w_mlast  = r_mlast;

    // Output register: held word first, then a word finishing now.
    if (w_xfer) begin
      w_mvalid = 1'b1;
      w_mdata  = r_asm;
      w_mbeats = r_hbeats;
      w_mlast  = r_hlast;
    end else if (w_fin && w_out_free) begin
      w_mvalid = 1'b1;
      w_mdata  = w_new_data;
      w_mbeats = w_new_cnt;
      w_mlast  = s_TLAST;
    end else if (w_flush && w_out_free) begin
      w_mvalid = 1'b1;
      w_mdata  = r_asm;
      w_mbeats = r_cnt;
      w_mlast  = 1'b0;
    end else if (m_TREADY) begin
      w_mvalid = 1'b0;
    end

    if (w_fin && (w_xfer || !w_out_free)) begin
      w_done   = 1'b1;
      w_asm    = w_new_data;
      w_hbeats = w_new_cnt;
      w_hlast  = s_TLAST;
      w_cnt    = '0;
    end else if (w_fin) begin
      w_done = 1'b0;
      w_asm  = '0;
      w_cnt  = '0;
    end else if (w_acc) begin
      w_done = 1'b0;
      w_asm  = w_new_data;
      w_cnt  = w_new_cnt;
    end else if (w_xfer) begin
      w_done = 1'b0;
      w_asm  = '0;
      w_cnt  = '0;
    end else if (w_flush) begin
      w_cnt = '0;
      if (w_out_free) begin
        w_asm = '0;
      end else begin
        w_done   = 1'b1;
        w_hbeats = r_cnt;
        w_hlast  = 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt    <= '0;
      r_asm    <= '0;
      r_done   <= 1'b0;
      r_hbeats <= '0;
      r_hlast  <= 1'b0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_mbeats <= '0;
      r_mlast  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt;
      r_asm    <= w_asm;
      r_done   <= w_done;
      r_hbeats <= w_hbeats;
      r_hlast  <= w_hlast;
      r_mvalid <= w_mvalid;
      r_mdata  <= w_mdata;
      r_mbeats <= w_mbeats;
      r_mlast  <= w_mlast;
    end
  end

  assign m_TVALID = r_mvalid;
  assign m_TDATA  = r_mdata;
  assign m_TBEATS = r_mbeats;
  assign m_TLAST  = r_mlast;

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Bench for axis_flit_deserializer: directed vectors checked against a queue model.
// Timeout checks follow DESER_FLUSH_TIMEOUT_EN.
module tb_axis_flit_deserializer;

  localparam int W  = 40;
  localparam int R  = 4;
  localparam int OW = W * R;
  localparam int CW = 3;
  localparam int TO = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          s_TVALID, s_TREADY, s_TLAST;
  logic [W-1:0]  s_TDATA;
  logic          m_TVALID, m_TREADY, m_TLAST;
  logic [OW-1:0] m_TDATA;
  logic [CW-1:0] m_TBEATS;

  always #5 ACLK = ~ACLK;

  axis_flit_deserializer #(
    .IN_WIDTH(W), .RATIO(R), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_TVALID(s_TVALID), .s_TREADY(s_TREADY),
    .s_TDATA(s_TDATA), .s_TLAST(s_TLAST),
    .m_TVALID(m_TVALID), .m_TREADY(m_TREADY),
    .m_TDATA(m_TDATA), .m_TBEATS(m_TBEATS), .m_TLAST(m_TLAST)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_stall = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [OW-1:0] d;
    int            b;
    logic          l;
  } exp_t;

  exp_t          q[$];
  logic [OW-1:0] mw = '0;
  int            mcnt = 0;
  int            midle = 0;
  logic          hold_p = 1'b0;
  logic [OW-1:0] hold_d;
  logic [CW-1:0] hold_b;
  logic          hold_l;
  int            hs_cyc[$];
  bit            rec = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Model: beats collected into words; words compared on each output handshake.
  always @(negedge ACLK) begin
    exp_t e;
    if (ARESET) begin
      q.delete();
      mw = '0;
      mcnt = 0;
      midle = 0;
      hold_p = 1'b0;
    end else begin
      if (hold_p)
        chk("hold_stable",
            192'({m_TVALID, m_TLAST, m_TBEATS, m_TDATA}),
            192'({1'b1, hold_l, hold_b, hold_d}));
      if (m_TVALID && m_TREADY) begin
        if (rec) hs_cyc.push_back(cyc);
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %h want none", m_TDATA);
        end else begin
          e = q.pop_front();
          chk("word_data", 192'(m_TDATA), 192'(e.d));
          chk("word_beats", 192'(m_TBEATS), 192'(e.b));
          chk("word_last", 192'(m_TLAST), 192'(e.l));
        end
      end
      hold_p = m_TVALID && !m_TREADY;
      hold_d = m_TDATA;
      hold_b = m_TBEATS;
      hold_l = m_TLAST;
      if (s_TVALID && s_TREADY) begin
        mw[mcnt*W +: W] = s_TDATA;
        mcnt++;
        midle = 0;
        if (mcnt == R || s_TLAST) begin
          q.push_back('{mw, mcnt, s_TLAST});
          mw = '0;
          mcnt = 0;
        end
      end else if (mcnt > 0) begin
        midle++;
`ifdef DESER_FLUSH_TIMEOUT_EN
        if (midle == TO) begin
          q.push_back('{mw, mcnt, 1'b0});
          mw = '0;
          mcnt = 0;
          midle = 0;
        end
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input logic [W-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    s_TVALID = 1'b1;
    s_TDATA  = d;
    s_TLAST  = l;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge ACLK);
      if (s_TREADY) done = 1'b1;
      else n_stall++;
      @(posedge ACLK);
      #1;
    end
    s_TVALID = 1'b0;
    s_TLAST  = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: beat %h not accepted in 64 cycles", d);
    end
  endtask

  initial begin
    logic [OW-1:0] e;
    int c0;
    int k;
    ARESET   = 1'b1;
    s_TVALID = 1'b0;
    s_TDATA  = '0;
    s_TLAST  = 1'b0;
    m_TREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_mvalid", 192'(m_TVALID), 192'(0));
    chk("rst_mdata", 192'(m_TDATA), 192'(0));
    chk("rst_mbeats", 192'(m_TBEATS), 192'(0));
    chk("rst_mlast", 192'(m_TLAST), 192'(0));
    chk("rst_sready", 192'(s_TREADY), 192'(0));
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_sready", 192'(s_TREADY), 192'(1));
    @(posedge ACLK);
    #1;

    // full word, latency 1
    send(40'h01, 1'b0);
    send(40'h02, 1'b0);
    send(40'h03, 1'b0);
    send(40'h04, 1'b1);
    @(negedge ACLK);
    e = {40'h04, 40'h03, 40'h02, 40'h01};
    chk("full_valid", 192'(m_TVALID), 192'(1));
    chk("full_data", 192'(m_TDATA), 192'(e));
    chk("full_beats", 192'(m_TBEATS), 192'(4));
    chk("full_last", 192'(m_TLAST), 192'(1));
    @(posedge ACLK);
    #1;

    // short message
    send(40'hAA, 1'b0);
    send(40'hBB, 1'b1);
    @(negedge ACLK);
    e = {40'h0, 40'h0, 40'hBB, 40'hAA};
    chk("short_valid", 192'(m_TVALID), 192'(1));
    chk("short_data", 192'(m_TDATA), 192'(e));
    chk("short_beats", 192'(m_TBEATS), 192'(2));
    chk("short_last", 192'(m_TLAST), 192'(1));
    @(posedge ACLK);
    #1;

    // backpressure: one word out, one held, then stall
    m_TREADY = 1'b0;
    for (int i = 1; i <= 8; i++) send(40'h100 + W'(i), 1'b0);
    s_TVALID = 1'b1;
    s_TDATA  = 40'h109;
    @(negedge ACLK);
    for (int j = 0; j < R; j++) e[j*W +: W] = 40'h101 + W'(j);
    chk("bp_sready", 192'(s_TREADY), 192'(0));
    chk("bp_mvalid", 192'(m_TVALID), 192'(1));
    chk("bp_mdata", 192'(m_TDATA), 192'(e));
    repeat (3) @(negedge ACLK);
    @(posedge ACLK);
    #1 m_TREADY = 1'b1;
    for (int i = 9; i <= 12; i++) send(40'h100 + W'(i), 1'b0);
    repeat (4) @(posedge ACLK);
    #1;
    chk("bp_drained", 192'(q.size()), 192'(0));

    // continuous streaming
    n_stall = 0;
    hs_cyc.delete();
    rec = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 40; i++) send(40'h200 + W'(i), 1'b0);
    repeat (3) @(posedge ACLK);
    #1 rec = 1'b0;
    chk("stream_stalls", 192'(n_stall), 192'(0));
    chk("stream_words", 192'(hs_cyc.size()), 192'(10));
    if (hs_cyc.size() == 10) begin
      chk("stream_first", 192'(hs_cyc[0] - c0), 192'(4));
      for (int j = 1; j < 10; j++)
        chk("stream_gap", 192'(hs_cyc[j] - hs_cyc[j-1]), 192'(4));
    end

    // reset mid-word
    send(40'h11, 1'b0);
    send(40'h22, 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    send(40'h31, 1'b0);
    send(40'h32, 1'b0);
    send(40'h33, 1'b0);
    send(40'h34, 1'b1);
    @(negedge ACLK);
    e = {40'h34, 40'h33, 40'h32, 40'h31};
    chk("rstmid_valid", 192'(m_TVALID), 192'(1));
    chk("rstmid_data", 192'(m_TDATA), 192'(e));
    chk("rstmid_beats", 192'(m_TBEATS), 192'(4));
    @(posedge ACLK);
    #1;

    // partial word left idle
    send(40'h51, 1'b0);
    send(40'h52, 1'b0);
    send(40'h53, 1'b0);
`ifdef DESER_FLUSH_TIMEOUT_EN
    k = 0;
    for (int t = 0; t < 200 && !m_TVALID; t++) begin
      @(negedge ACLK);
      k++;
    end
    e = {40'h0, 40'h53, 40'h52, 40'h51};
    chk("to_latency", 192'(k), 192'(17));
    chk("to_data", 192'(m_TDATA), 192'(e));
    chk("to_beats", 192'(m_TBEATS), 192'(3));
    chk("to_last", 192'(m_TLAST), 192'(0));
    @(posedge ACLK);
    #1;
`else
    k = 0;
    repeat (100) begin
      @(negedge ACLK);
      if (m_TVALID) k++;
    end
    chk("no_timeout", 192'(k), 192'(0));
    @(posedge ACLK);
    #1 ARESET = 1'b1;
    @(posedge ACLK);
    #1 ARESET = 1'b0;
`endif

    repeat (3) @(posedge ACLK);
    #1;
    chk("end_queue", 192'(q.size()), 192'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
